// File: rtl/aes_enc_arbiter_pkg.sv
// Shared types and constants for the AES encryption-core arbiter.
package aes_enc_arbiter_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int DEFAULT_TIMEOUT = 32;
    localparam int CYCLE_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/aes_enc_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted valid at or after ptr, with wrap.
module aes_rr_picker
    import aes_enc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic logic [IDX_W-1:0] cand(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_REQ;
        return IDX_W'(sum);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && valid[cand(ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = cand(ptr, k);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Round-robin front end that serialises AES-128 jobs from NUM_REQ requesters
// onto one encryption core and returns a single completion per job.
module aes_enc_arbiter
    import aes_enc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [AES_BLOCK_W-1:0]         rsp_data,
    output logic                           rsp_err,
    output logic                           core_reset_n,
    output logic [AES_BLOCK_W-1:0]         core_in,
    output logic [AES_BLOCK_W-1:0]         core_key,
    input  logic [AES_BLOCK_W-1:0]         core_out,
    input  logic                           core_ready
);
    localparam int                     IDX_W          = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]       LAST_IDX       = IDX_W'(NUM_REQ - 1);
    localparam logic [CYCLE_CNT_W-1:0] LAST_RUN_CYCLE = CYCLE_CNT_W'(TIMEOUT - 1);

    arb_state_e             state;
    logic [IDX_W-1:0]       ptr;
    logic [AES_BLOCK_W-1:0] op_in;
    logic [AES_BLOCK_W-1:0] op_key;
    logic [CYCLE_CNT_W-1:0] cycle_cnt;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic                   accept;

    aes_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Only offer a grant while idle and out of reset; the winner's valid is
    // already high, so offering ready is the handshake.
    assign accept    = reset_n && (state == ST_IDLE) && grant_any;
    assign req_ready = accept ? grant : '0;

    assign core_in  = op_in;
    assign core_key = op_key;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            op_in        <= '0;
            op_key       <= '0;
            cycle_cnt    <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            core_reset_n <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    core_reset_n <= 1'b0;
                    if (accept) begin
                        op_in  <= req_data[AES_BLOCK_W*grant_idx +: AES_BLOCK_W];
                        op_key <= req_key[AES_BLOCK_W*grant_idx +: AES_BLOCK_W];
                        rsp_id <= grant_idx;
                        ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Core samples op_in/op_key during this low cycle.
                    cycle_cnt    <= '0;
                    core_reset_n <= 1'b1;
                    state        <= ST_RUN;
                end
                ST_RUN: begin
                    // Success is checked first so a result arriving on the
                    // final allowed cycle is not reported as a timeout.
                    if (core_ready) begin
                        rsp_data     <= core_out;
                        rsp_err      <= 1'b0;
                        rsp_valid    <= 1'b1;
                        core_reset_n <= 1'b0;
                        state        <= ST_RESP;
                    end else if (cycle_cnt == LAST_RUN_CYCLE) begin
                        rsp_data     <= '0;
                        rsp_err      <= 1'b1;
                        rsp_valid    <= 1'b1;
                        core_reset_n <= 1'b0;
                        state        <= ST_RESP;
                    end else begin
                        cycle_cnt <= cycle_cnt + CYCLE_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    core_reset_n <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    rsp_valid    <= 1'b0;
                    core_reset_n <= 1'b0;
                end
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(req_ready));

    a_rsp_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id) && $stable(rsp_err)));

    a_no_ready_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (state != ST_IDLE) |-> (req_ready == '0));

endmodule

// File: doc/aes_enc_arbiter.md
AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter TIMEOUT, default 32, maximum RUN cycles waiting for core_ready before error completion.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester job request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 req_data  input  NUM_REQ*128  plaintext, slice i = bits [128*i+:128], byte 0 at bits [7:0].
REQ-008 req_key  input  NUM_REQ*128  key, same slicing and byte order.
REQ-009 rsp_valid  output  1  completion available.
REQ-010 rsp_ready  input  1  completion consumer accept.
REQ-011 rsp_id  output  $clog2(NUM_REQ)  index of requester owning the completion.
REQ-012 rsp_data  output  128  ciphertext, zero on error.
REQ-013 rsp_err  output  1  completion ended by timeout.
REQ-014 core_reset_n  output  1  core load/restart; core captures core_in/core_key while low.
REQ-015 core_in  output  128  plaintext to core.
REQ-016 core_key  output  128  key to core.
REQ-017 core_out  input  128  core ciphertext.
REQ-018 core_ready  input  1  core done, level, cleared by core_reset_n low.

Function
REQ-019 FSM states IDLE, LOAD, RUN, RESP; one job in flight.
REQ-020 IDLE: core_reset_n=0; req_ready asserted combinationally for the round-robin winner among asserted req_valid only.
REQ-021 Round-robin: search starts at pointer ptr, ascending with wrap; after grant to i, ptr = (i+1) mod NUM_REQ; ptr unchanged when no grant.
REQ-022 On handshake (valid&ready) in IDLE: register slice i of req_data/req_key into op_in/op_key, record id, go LOAD.
REQ-023 core_in/core_key always driven from op_in/op_key registers, never directly from request ports.
REQ-024 LOAD: one cycle, core_reset_n=0, then RUN; guarantees the core samples registered operands.
REQ-025 RUN: core_reset_n=1; 16-bit cycle counter cleared on entry, increments each RUN cycle.
REQ-026 RUN, core_ready=1: capture core_out into rsp_data, rsp_err=0, go RESP.
REQ-027 RUN, counter reaches TIMEOUT with core_ready=0: rsp_data=0, rsp_err=1, go RESP.
REQ-028 core_ready and timeout in same cycle: success wins.
REQ-029 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err stable until rsp_ready; on rsp_valid&rsp_ready go IDLE.
REQ-030 RESP: core_reset_n=0 (core parked); no req_ready asserted.
REQ-031 Requester deasserting req_valid before handshake is legal; no grant or state change results.
REQ-032 Back-to-back: rsp handshake cycle returns to IDLE; next grant earliest one cycle later.
REQ-033 Latency with team core: handshake at T, LOAD T+1, RUN from T+2, rsp_valid cycle after core_ready first seen.

Reset
REQ-034 reset_n low: state=IDLE, ptr=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, op_in=0, op_key=0, counter=0, core_reset_n=0, req_ready=0.
REQ-035 Reset mid-job (LOAD/RUN/RESP) abandons job silently; no completion emitted.

Structure
REQ-036 Shared package holds state enum, AES_BLOCK_W=128 constant, default TIMEOUT.
REQ-037 One sub-module, aes_rr_picker: combinational round-robin grant from valid vector and ptr.

Verification
REQ-038 Requester 0, key 128'h0f0e0d0c0b0a09080706050403020100, data 128'hffeeddccbbaa99887766554433221100 -> rsp_id=0, rsp_err=0, rsp_data=128'h5ac5b47080b7cdd830047b6ad8e0c469.
REQ-039 All 4 requesters valid continuously -> grants in order 0,1,2,3,0; each rsp_id matches granted order.
REQ-040 core_ready tied 0 (stub core) -> rsp_valid after exactly TIMEOUT RUN cycles, rsp_err=1, rsp_data=0.
REQ-041 rsp_ready held 0 for 10 cycles -> rsp outputs stable, no req_ready asserted, handshake on release returns IDLE.
REQ-042 reset_n pulsed low during RUN -> no rsp_valid, ptr=0, next request from requester 2 granted and completes correctly.
REQ-043 Requester 1 drops req_valid while requester 0 busy -> never granted; ptr skips to next active requester.
